// File: rtl/song_sequencer_if.sv
// Sequencer bus: control inputs, note ROM read port and tone-generator outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the sequencer is the only master of rom_addr/note.
// master = song_sequencer side, slave = player controls + ROM + tone generator.
interface song_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              play;
    logic              restart;
    logic              loop_en;
    logic [1:0]        tempo_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        note;
    logic              playing;
    logic              beat_pulse;
    logic              song_done;

    modport master (
        input  play, restart, loop_en, tempo_sel, rom_data,
        output rom_addr, note, playing, beat_pulse, song_done
    );

    modport slave (
        output play, restart, loop_en, tempo_sel, rom_data,
        input  rom_addr, note, playing, beat_pulse, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song player: walks a note ROM at a selectable tempo and drives the tone generator note code.
// Latency: 2-cycle fetch per entry, then beat_len cycles of PLAY (+GAP); all outputs registered.
// Backpressure: none; play=0 freezes the player in place, restart rewinds to address 0.
// Ports: CLK100MHZ, reset (sync, active high), bus (song_sequencer_if.master):
//   play/restart/loop_en/tempo_sel controls, rom_addr/rom_data ROM port,
//   note/playing/beat_pulse/song_done to the tone generator.
module song_sequencer #(
    parameter int BEAT_DIV = 16777216,
    parameter int GAP_DIV  = 1048576,
    parameter int ADDR_W   = 8
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    song_sequencer_if.master bus
);
    // Sized for the slowest tempo (BEAT_DIV*2) so the beat count never overflows.
    localparam int CNT_W = $clog2(2 * BEAT_DIV + 1);

    localparam logic [CNT_W-1:0] BEAT_X1   = CNT_W'(BEAT_DIV);
    localparam logic [CNT_W-1:0] BEAT_HALF = CNT_W'(BEAT_DIV / 2);
    localparam logic [CNT_W-1:0] BEAT_DBL  = CNT_W'(2 * BEAT_DIV);
    localparam logic [CNT_W-1:0] BEAT_QTR  = CNT_W'(BEAT_DIV / 4);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rom_addr_r;
    logic              fetch_2nd;   // 0 = waiting on ROM latency, 1 = rom_data valid this cycle
    logic [CNT_W-1:0]  cnt;
    logic              cur_tie;
    logic [5:0]        cur_note;    // latched entry, restores the note after a pause
    logic [7:0]        note_r;
    logic              playing_r;
    logic              beat_pulse_r;
    logic              song_done_r;

    logic [CNT_W-1:0]  beat_len;
    logic [CNT_W-1:0]  play_len;
    logic              is_end;
    logic              last_addr;
    logic              entry_end;

    // Tempo is only consumed at the second FETCH cycle, so a change mid-entry
    // takes effect from the next entry.
    always_comb begin
        beat_len = BEAT_X1;
        case (bus.tempo_sel)
            2'd0:    beat_len = BEAT_X1;
            2'd1:    beat_len = BEAT_HALF;
            2'd2:    beat_len = BEAT_DBL;
            default: beat_len = BEAT_QTR;
        endcase
    end

    // Untied entries give up the last GAP_DIV cycles of the beat to silence.
    assign play_len  = bus.rom_data[6] ? beat_len : beat_len - GAP_LEN;
    assign is_end    = (bus.rom_data == 8'hFF);
    assign last_addr = &rom_addr_r;
    assign entry_end = ((state == S_PLAY) && cur_tie && (cnt <= CNT_ONE)) ||
                       ((state == S_GAP) && (cnt <= CNT_ONE));

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state        <= S_IDLE;
            rom_addr_r   <= '0;
            fetch_2nd    <= 1'b0;
            cnt          <= '0;
            cur_tie      <= 1'b0;
            cur_note     <= '0;
            note_r       <= '0;
            playing_r    <= 1'b0;
            beat_pulse_r <= 1'b0;
            song_done_r  <= 1'b0;
        end else if (bus.restart) begin
            state        <= bus.play ? S_FETCH : S_IDLE;
            rom_addr_r   <= '0;
            fetch_2nd    <= 1'b0;
            cnt          <= '0;
            cur_tie      <= 1'b0;
            cur_note     <= '0;
            note_r       <= '0;
            playing_r    <= bus.play;
            beat_pulse_r <= 1'b0;
            song_done_r  <= 1'b0;
        end else begin
            beat_pulse_r <= 1'b0;
            song_done_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    note_r    <= '0;
                    fetch_2nd <= 1'b0;
                    playing_r <= bus.play;
                    if (bus.play) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH, S_PLAY, S_GAP: begin
                    if (!bus.play) begin
                        // Pause: hold state, count and address; a fetch restarts from its first cycle.
                        note_r    <= '0;
                        playing_r <= 1'b0;
                        fetch_2nd <= 1'b0;
                    end else begin
                        playing_r <= 1'b1;
                        note_r    <= '0;
                        if (state == S_FETCH) begin
                            fetch_2nd <= ~fetch_2nd;
                            if (fetch_2nd) begin
                                if (!is_end) begin
                                    state        <= S_PLAY;
                                    cur_note     <= bus.rom_data[5:0];
                                    cur_tie      <= bus.rom_data[6];
                                    note_r       <= {2'b00, bus.rom_data[5:0]};
                                    beat_pulse_r <= 1'b1;
                                    cnt          <= play_len;
                                end else if (bus.loop_en) begin
                                    rom_addr_r <= '0;
                                end else begin
                                    state       <= S_DONE;
                                    song_done_r <= 1'b1;
                                    playing_r   <= 1'b0;
                                end
                            end
                        end else if (state == S_PLAY) begin
                            note_r <= {2'b00, cur_note};
                            if (cnt > CNT_ONE) begin
                                cnt <= cnt - CNT_ONE;
                            end else if (!cur_tie) begin
                                state  <= S_GAP;
                                cnt    <= GAP_LEN;
                                note_r <= '0;
                            end
                        end else begin
                            if (cnt > CNT_ONE) begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end

                        // Entry finished: step the address; running off the top of the
                        // ROM behaves like an end marker.
                        if (entry_end) begin
                            cnt    <= '0;
                            note_r <= '0;
                            if (last_addr && !bus.loop_en) begin
                                state       <= S_DONE;
                                song_done_r <= 1'b1;
                                playing_r   <= 1'b0;
                            end else begin
                                rom_addr_r <= rom_addr_r + ADDR_W'(1);
                                state      <= S_FETCH;
                            end
                        end
                    end
                end

                S_DONE: begin
                    note_r    <= '0;
                    playing_r <= 1'b0;
                    if (!bus.play) begin
                        state      <= S_IDLE;
                        rom_addr_r <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_r;
    assign bus.note       = note_r;
    assign bus.playing    = playing_r;
    assign bus.beat_pulse = beat_pulse_r;
    assign bus.song_done  = song_done_r;
endmodule
